// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - pipeline, forwarding and data-SRAM signals of the execute stage
interface exe_stage_if #(
    parameter int DS_TO_ES_BUS_WD = 159,
    parameter int ES_TO_MS_BUS_WD = 76
);
    logic                       ms_allowin;
    logic                       es_allowin;
    logic                       ds_to_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic [4:0]                 es_to_ds_dest;
    logic                       es_to_ds_load;
    logic                       es_to_ds_data_ok;
    logic [31:0]                es_to_ds_result;
    logic                       data_sram_en;
    logic [3:0]                 data_sram_we;
    logic [31:0]                data_sram_addr;
    logic [31:0]                data_sram_wdata;

    modport slave (
        input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
        output es_allowin, es_to_ms_valid, es_to_ms_bus,
        output es_to_ds_dest, es_to_ds_load, es_to_ds_data_ok, es_to_ds_result,
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );

    modport master (
        output ms_allowin, ds_to_es_valid, ds_to_es_bus,
        input  es_allowin, es_to_ms_valid, es_to_ms_bus,
        input  es_to_ds_dest, es_to_ds_load, es_to_ds_data_ok, es_to_ds_result,
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - LoongArch32 execute stage: ALU, iterative divider, data-SRAM request
module exe_stage (
    input  logic        clk,
    input  logic        resetn,
    exe_stage_if.slave  es_if
);
    localparam int DS_TO_ES_BUS_WD = 159;

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

    logic                       es_valid_q, es_valid_d;
    logic [DS_TO_ES_BUS_WD-1:0] bus_q, bus_d;
    div_state_e                 div_state_q;
    logic [4:0]                 div_cnt_q;
    logic [31:0]                rem_q, quo_q, dvs_q;

    logic [3:0]  div_op;
    logic [11:0] alu_op;
    logic [4:0]  load_op;
    logic [2:0]  store_op;
    logic        res_from_mem, gr_we;
    logic [4:0]  dest;
    logic [31:0] src1, src2, st_data, pc;

    assign {div_op, alu_op, load_op, store_op, res_from_mem, gr_we, dest,
            src1, src2, st_data, pc} = bus_q;

    logic is_div, es_ready_go, es_allowin, es_to_ms_valid;
    assign is_div         = |div_op;
    assign es_ready_go    = !is_div || (div_state_q == DIV_DONE);
    assign es_allowin     = !es_valid_q || (es_ready_go && es_if.ms_allowin);
    assign es_to_ms_valid = es_valid_q && es_ready_go;

    always_comb begin
        es_valid_d = es_valid_q;
        bus_d      = bus_q;
        if (es_allowin) begin
            es_valid_d = es_if.ds_to_es_valid;
            if (es_if.ds_to_es_valid) begin
                bus_d = es_if.ds_to_es_bus;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid_q <= 1'b0;
            bus_q      <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            bus_q      <= bus_d;
        end
    end

    // ALU: alu_op is one-hot, so OR-ing the masked results selects exactly one
    logic [31:0] add_res, sub_res, slt_res, sltu_res, sll_res, srl_res, sra_res, alu_result;
    assign add_res  = src1 + src2;
    assign sub_res  = src1 - src2;
    assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
    assign sltu_res = {31'b0, src1 < src2};
    assign sll_res  = src1 << src2[4:0];
    assign srl_res  = src1 >> src2[4:0];
    assign sra_res  = 32'($signed(src1) >>> src2[4:0]);

    assign alu_result = ({32{alu_op[0]}}  & add_res)
                      | ({32{alu_op[1]}}  & sub_res)
                      | ({32{alu_op[2]}}  & slt_res)
                      | ({32{alu_op[3]}}  & sltu_res)
                      | ({32{alu_op[4]}}  & (src1 & src2))
                      | ({32{alu_op[5]}}  & ~(src1 | src2))
                      | ({32{alu_op[6]}}  & (src1 | src2))
                      | ({32{alu_op[7]}}  & (src1 ^ src2))
                      | ({32{alu_op[8]}}  & sll_res)
                      | ({32{alu_op[9]}}  & srl_res)
                      | ({32{alu_op[10]}} & sra_res)
                      | ({32{alu_op[11]}} & src2);

    // Divider works on magnitudes; signs are restored from the held bus register
    logic        div_signed, div_is_mod, quo_neg, rem_neg;
    logic [31:0] src1_abs, src2_abs, div_sub, quo_fix, rem_fix, div_result;
    logic [32:0] div_shift;
    logic        div_ge;

    assign div_signed = div_op[0] | div_op[1];
    assign div_is_mod = div_op[1] | div_op[3];
    assign src1_abs   = (div_signed && src1[31]) ? (~src1 + 32'd1) : src1;
    assign src2_abs   = (div_signed && src2[31]) ? (~src2 + 32'd1) : src2;
    assign div_shift  = {rem_q, quo_q[31]};
    assign div_ge     = div_shift >= {1'b0, dvs_q};
    assign div_sub    = div_shift[31:0] - dvs_q;
    assign quo_neg    = div_signed && (src1[31] ^ src2[31]);
    assign rem_neg    = div_signed && src1[31];
    assign quo_fix    = quo_neg ? (~quo_q + 32'd1) : quo_q;
    assign rem_fix    = rem_neg ? (~rem_q + 32'd1) : rem_q;
    assign div_result = div_is_mod ? rem_fix : quo_fix;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_state_q <= DIV_IDLE;
            div_cnt_q   <= 5'd0;
            rem_q       <= 32'd0;
            quo_q       <= 32'd0;
            dvs_q       <= 32'd0;
        end else begin
            case (div_state_q)
                DIV_IDLE: begin
                    if (es_valid_q && is_div) begin
                        div_state_q <= DIV_BUSY;
                        div_cnt_q   <= 5'd0;
                        rem_q       <= 32'd0;
                        quo_q       <= src1_abs;
                        dvs_q       <= src2_abs;
                    end
                end
                DIV_BUSY: begin
                    div_cnt_q <= div_cnt_q + 5'd1;
                    rem_q     <= div_ge ? div_sub : div_shift[31:0];
                    quo_q     <= {quo_q[30:0], div_ge};
                    if (div_cnt_q == 5'd31) begin
                        div_state_q <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (es_to_ms_valid && es_if.ms_allowin) begin
                        div_state_q <= DIV_IDLE;
                    end
                end
                default: div_state_q <= DIV_IDLE;
            endcase
        end
    end

    logic [31:0] es_result;
    assign es_result = is_div ? div_result : alu_result;

    logic [3:0]  sram_we;
    logic [31:0] sram_wdata;
    always_comb begin
        sram_we    = 4'b0000;
        sram_wdata = st_data;
        if (store_op[2]) begin
            sram_we = 4'b1111;
        end else if (store_op[1]) begin
            sram_we    = add_res[1] ? 4'b1100 : 4'b0011;
            sram_wdata = {2{st_data[15:0]}};
        end else if (store_op[0]) begin
            sram_we    = 4'b0001 << add_res[1:0];
            sram_wdata = {4{st_data[7:0]}};
        end
    end

    assign es_if.es_allowin       = es_allowin;
    assign es_if.es_to_ms_valid   = es_to_ms_valid;
    assign es_if.es_to_ms_bus     = {load_op, res_from_mem, gr_we, dest, es_result, pc};
    assign es_if.es_to_ds_dest    = (es_valid_q && gr_we) ? dest : 5'd0;
    assign es_if.es_to_ds_load    = es_valid_q && res_from_mem;
    assign es_if.es_to_ds_data_ok = !es_valid_q || es_ready_go;
    assign es_if.es_to_ds_result  = es_result;
    // The request fires only in the cycle the instruction is handed to MS
    assign es_if.data_sram_en     = es_valid_q && es_if.ms_allowin && (|load_op || |store_op);
    assign es_if.data_sram_we     = sram_we;
    assign es_if.data_sram_addr   = add_res;
    assign es_if.data_sram_wdata  = sram_wdata;
endmodule
